// File: rtl/onchip_mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// onchip_arb_pkg
// Shared constants and types for the on-chip frame memory port arbiter.
//   DEF_ADDR_W / DEF_DATA_W / DEF_BE_W : default memory port geometry
//   req_id_t                           : requester id (0 = m0, 1 = m1)
//   LAST_GRANT_RST                     : reset value of the round-robin pointer
// ----------------------------------------------------------------------------
package onchip_arb_pkg;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

    typedef logic req_id_t;

    // Pointer starts at m1 so that m0 wins the first tie after reset.
    localparam req_id_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/onchip_mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// onchip_mem_port_arbiter_if
// Avalon-MM requester bundle for one master of the frame memory arbiter.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives waitrequest/readdata/readdatavalid
//   slave  modport : the arbiter side of the same bundle
// ----------------------------------------------------------------------------
interface onchip_mem_port_arbiter_if #(
    parameter int ADDR_W = onchip_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = onchip_arb_pkg::DEF_DATA_W,
    parameter int BE_W   = onchip_arb_pkg::DEF_BE_W
);

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_mem_port_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//   req_i        : active requests {m1, m0}
//   last_grant_i : requester granted most recently (register lives in the top)
//   lock_i       : per-requester effective lock (only with ONCHIP_ARB_LOCK_EN)
//   gnt_o        : one-hot grant {m1, m0}, zero when nobody is granted
//   gnt_id_o     : id of the granted requester (0 when no grant)
// Configuration macro: ONCHIP_ARB_LOCK_EN
// ----------------------------------------------------------------------------
module rr_arb2
    import onchip_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    last_grant_i,
`ifdef ONCHIP_ARB_LOCK_EN
    input  logic [1:0] lock_i,
`endif
    output logic [1:0] gnt_o,
    output req_id_t    gnt_id_o
);

    always_comb begin
        gnt_o = 2'b00;
`ifdef ONCHIP_ARB_LOCK_EN
        // A locking owner keeps the port even while idle.
        if (lock_i[last_grant_i]) begin
            if (req_i[last_grant_i]) begin
                gnt_o[last_grant_i] = 1'b1;
            end
        end else
`endif
        begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        gnt_id_o = gnt_o[1];
    end

endmodule

// File: rtl/onchip_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// onchip_mem_port_arbiter
// Shares port 2 of the dual-port frame memory between two Avalon-MM masters
// with round-robin arbitration and one-cycle read latency tracking.
//   clk, reset_n   : clock (also clocks memory port 2), async active-low reset
//   m0, m1         : requester bundles (slave modport)
//   m0_lock/m1_lock: bus lock requests (only with ONCHIP_ARB_LOCK_EN)
//   mem_*          : to address2/chipselect2/write2/writedata2/byteenable2/
//                    clken2, and readdata2 back
// Configuration macro: ONCHIP_ARB_LOCK_EN
// ----------------------------------------------------------------------------
module onchip_mem_port_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_port_arbiter_if.slave m0,
    onchip_mem_port_arbiter_if.slave m1,
`ifdef ONCHIP_ARB_LOCK_EN
    input  logic                m0_lock,
    input  logic                m1_lock,
`endif
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [BE_W-1:0]     mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    req_id_t    gnt_id;
    logic       any_gnt;
    logic       sel_read;
    logic       sel_write;

    req_id_t    last_grant_q, last_grant_d;
    req_id_t    rd_owner_q,   rd_owner_d;
    logic       rd_pending_q, rd_pending_d;

    // Requests are masked during reset so nothing is granted and every
    // master sees waitrequest high.
    assign req = reset_n ? {m1.read | m1.write, m0.read | m0.write} : 2'b00;

`ifdef ONCHIP_ARB_LOCK_EN
    logic [1:0] granted_once_q, granted_once_d;
    logic [1:0] lock_eff;

    // A lock only counts once its owner has actually won the port.
    assign lock_eff       = {m1_lock, m0_lock} & granted_once_q;
    assign granted_once_d = granted_once_q | gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            granted_once_q <= 2'b00;
        end else begin
            granted_once_q <= granted_once_d;
        end
    end
`endif

    rr_arb2 u_rr_arb2 (
        .req_i        (req),
        .last_grant_i (last_grant_q),
`ifdef ONCHIP_ARB_LOCK_EN
        .lock_i       (lock_eff),
`endif
        .gnt_o        (gnt),
        .gnt_id_o     (gnt_id)
    );

    always_comb begin
        any_gnt      = |gnt;
        // read+write together is a protocol error and is handled as a write.
        sel_write    = gnt_id ? m1.write : m0.write;
        sel_read     = (gnt_id ? m1.read : m0.read) & ~sel_write;
        last_grant_d = any_gnt ? gnt_id : last_grant_q;
        rd_pending_d = any_gnt & sel_read;
        rd_owner_d   = rd_pending_d ? gnt_id : rd_owner_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= LAST_GRANT_RST;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign mem_address    = gnt_id ? m1.address    : m0.address;
    assign mem_writedata  = gnt_id ? m1.writedata  : m0.writedata;
    assign mem_byteenable = gnt_id ? m1.byteenable : m0.byteenable;
    assign mem_chipselect = any_gnt;
    assign mem_write      = any_gnt & sel_write;
    assign mem_clken      = 1'b1;

    assign m0.waitrequest   = ~gnt[0];
    assign m1.waitrequest   = ~gnt[1];

    // Memory output is unregistered, so data lines up with the pending flag.
    assign m0.readdatavalid = rd_pending_q & (rd_owner_q == 1'b0);
    assign m1.readdatavalid = rd_pending_q & (rd_owner_q == 1'b1);
    assign m0.readdata      = m0.readdatavalid ? mem_readdata : '0;
    assign m1.readdata      = m1.readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
module tb_onchip_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [16:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic        mem_clken;
    logic [15:0] mem_readdata;
`ifdef ONCHIP_ARB_LOCK_EN
    logic        m0_lock;
    logic        m1_lock;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    onchip_mem_port_arbiter_if m0_if ();
    onchip_mem_port_arbiter_if m1_if ();

    onchip_mem_port_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
`ifdef ONCHIP_ARB_LOCK_EN
        .m0_lock        (m0_lock),
        .m1_lock        (m1_lock),
`endif
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered address, unregistered output, byte-enabled writes.
    logic [15:0] mem [0:131071];
    logic [16:0] mem_addr_q;
    logic        pre_en = 1'b0;
    logic [16:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_chipselect && mem_clken) begin
            mem_addr_q <= mem_address;
            if (mem_write) begin
                if (mem_byteenable[0]) mem[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) mem[mem_address][15:8] <= mem_writedata[15:8];
            end
        end
    end
    assign mem_readdata = mem[mem_addr_q];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0;
        m0_if.writedata = '0; m0_if.byteenable = 2'b11;
        m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
        m1_if.writedata = '0; m1_if.byteenable = 2'b11;
`ifdef ONCHIP_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    endtask

    task automatic apply_reset();
        idle_all();
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic preload(input logic [16:0] a, input logic [15:0] d);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        next_cycle();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        reset_n = 1'b0;
        m0_if.read = 1'b1; m0_if.address = 17'h00001;
        m1_if.write = 1'b1; m1_if.address = 17'h00002;
        @(negedge clk);
        tests_run++; if (m0_if.waitrequest !== 1'b1) begin tests_failed++; $display("FAIL rst_m0_wait: got %b want 1", m0_if.waitrequest); end
        tests_run++; if (m1_if.waitrequest !== 1'b1) begin tests_failed++; $display("FAIL rst_m1_wait: got %b want 1", m1_if.waitrequest); end
        tests_run++; if (mem_chipselect !== 1'b0) begin tests_failed++; $display("FAIL rst_cs: got %b want 0", mem_chipselect); end
        tests_run++; if ({m1_if.readdatavalid, m0_if.readdatavalid} !== 2'b00) begin tests_failed++; $display("FAIL rst_rdv: got %b want 00", {m1_if.readdatavalid, m0_if.readdatavalid}); end
        tests_run++; if (mem_clken !== 1'b1) begin tests_failed++; $display("FAIL rst_clken: got %b want 1", mem_clken); end
        next_cycle();
        idle_all();
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        preload(17'h00010, 16'hBEEF);
        m0_if.read = 1'b1; m0_if.address = 17'h00010;
        @(negedge clk);
        tests_run++; if (m0_if.waitrequest !== 1'b0) begin tests_failed++; $display("FAIL sr_m0_wait: got %b want 0", m0_if.waitrequest); end
        tests_run++; if (m1_if.waitrequest !== 1'b1) begin tests_failed++; $display("FAIL sr_m1_wait: got %b want 1", m1_if.waitrequest); end
        tests_run++; if ({mem_chipselect, mem_write} !== 2'b10) begin tests_failed++; $display("FAIL sr_cs_wr: got %b want 10", {mem_chipselect, mem_write}); end
        tests_run++; if (mem_address !== 17'h00010) begin tests_failed++; $display("FAIL sr_addr: got %h want 00010", mem_address); end
        next_cycle();
        idle_all();
        @(negedge clk);
        tests_run++; if (m0_if.readdatavalid !== 1'b1) begin tests_failed++; $display("FAIL sr_rdv: got %b want 1", m0_if.readdatavalid); end
        tests_run++; if (m0_if.readdata !== 16'hBEEF) begin tests_failed++; $display("FAIL sr_data: got %h want beef", m0_if.readdata); end
        tests_run++; if ({m1_if.readdatavalid, m1_if.readdata} !== 17'h0) begin tests_failed++; $display("FAIL sr_m1_idle: got %h want 0", {m1_if.readdatavalid, m1_if.readdata}); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (m0_if.readdatavalid !== 1'b0) begin tests_failed++; $display("FAIL sr_rdv_once: got %b want 0", m0_if.readdatavalid); end
    endtask

    task automatic test_tie();
        apply_reset();
        preload(17'h00020, 16'h1111);
        preload(17'h00030, 16'h2222);
        m0_if.read = 1'b1; m0_if.address = 17'h00020;
        m1_if.read = 1'b1; m1_if.address = 17'h00030;
        @(negedge clk);
        tests_run++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin tests_failed++; $display("FAIL tie_c0_wait: got %b want 01", {m0_if.waitrequest, m1_if.waitrequest}); end
        next_cycle();
        m0_if.read = 1'b0;
        @(negedge clk);
        tests_run++; if (m1_if.waitrequest !== 1'b0) begin tests_failed++; $display("FAIL tie_c1_m1_wait: got %b want 0", m1_if.waitrequest); end
        tests_run++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b10) begin tests_failed++; $display("FAIL tie_c1_rdv: got %b want 10", {m0_if.readdatavalid, m1_if.readdatavalid}); end
        tests_run++; if (m0_if.readdata !== 16'h1111) begin tests_failed++; $display("FAIL tie_c1_data: got %h want 1111", m0_if.readdata); end
        next_cycle();
        m1_if.read = 1'b0;
        @(negedge clk);
        tests_run++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b01) begin tests_failed++; $display("FAIL tie_c2_rdv: got %b want 01", {m0_if.readdatavalid, m1_if.readdatavalid}); end
        tests_run++; if (m1_if.readdata !== 16'h2222) begin tests_failed++; $display("FAIL tie_c2_data: got %h want 2222", m1_if.readdata); end
        next_cycle();
    endtask

    task automatic test_contention();
        int k0 = 0;
        int k1 = 0;
        apply_reset();
        for (int j = 0; j < 5; j++) begin
            preload(17'(32'h100 + j), 16'hAAAA);
            preload(17'(32'h200 + j), 16'hAAAA);
        end
        for (int i = 0; i < 8; i++) begin
            m0_if.write = 1'b1; m0_if.address = 17'(32'h100 + k0);
            m0_if.writedata = 16'(32'h7F10 + k0); m0_if.byteenable = 2'b01;
            m1_if.write = 1'b1; m1_if.address = 17'(32'h200 + k1);
            m1_if.writedata = 16'(32'hC0D0 + k1); m1_if.byteenable = 2'b11;
            @(negedge clk);
            tests_run++;
            if ({m0_if.waitrequest, m1_if.waitrequest} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL cont_grant[%0d]: got wait %b want %b", i, {m0_if.waitrequest, m1_if.waitrequest}, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (!m0_if.waitrequest) k0++;
            if (!m1_if.waitrequest) k1++;
            next_cycle();
        end
        idle_all();
        next_cycle();
        tests_run++; if (k0 != 4 || k1 != 4) begin tests_failed++; $display("FAIL cont_counts: got m0=%0d m1=%0d want 4/4", k0, k1); end
        for (int j = 0; j < 4; j++) begin
            tests_run++; if (mem[17'(32'h100 + j)] !== 16'(32'hAA10 + j)) begin tests_failed++; $display("FAIL cont_m0_mem[%0d]: got %h want %h", j, mem[17'(32'h100 + j)], 16'(32'hAA10 + j)); end
            tests_run++; if (mem[17'(32'h200 + j)] !== 16'(32'hC0D0 + j)) begin tests_failed++; $display("FAIL cont_m1_mem[%0d]: got %h want %h", j, mem[17'(32'h200 + j)], 16'(32'hC0D0 + j)); end
        end
        tests_run++; if (mem[17'h00104] !== 16'hAAAA) begin tests_failed++; $display("FAIL cont_untouched: got %h want aaaa", mem[17'h00104]); end
    endtask

    task automatic test_write_read();
        m1_if.write = 1'b1; m1_if.address = 17'h1FFFF;
        m1_if.writedata = 16'h1234; m1_if.byteenable = 2'b11;
        @(negedge clk);
        tests_run++; if ({m1_if.waitrequest, mem_write} !== 2'b01) begin tests_failed++; $display("FAIL wr_accept: got %b want 01", {m1_if.waitrequest, mem_write}); end
        next_cycle();
        idle_all();
        m0_if.read = 1'b1; m0_if.address = 17'h1FFFF;
        @(negedge clk);
        tests_run++; if (m0_if.waitrequest !== 1'b0) begin tests_failed++; $display("FAIL wr_rd_wait: got %b want 0", m0_if.waitrequest); end
        next_cycle();
        idle_all();
        @(negedge clk);
        tests_run++; if ({m0_if.readdatavalid, m0_if.readdata} !== {1'b1, 16'h1234}) begin tests_failed++; $display("FAIL wr_rd_data: got %b/%h want 1/1234", m0_if.readdatavalid, m0_if.readdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        preload(17'h00040, 16'h5A5A);
        m0_if.read = 1'b1; m0_if.address = 17'h00040;
        @(negedge clk);
        tests_run++; if (m0_if.waitrequest !== 1'b0) begin tests_failed++; $display("FAIL rmr_accept: got %b want 0", m0_if.waitrequest); end
        next_cycle();
        reset_n = 1'b0;
        m1_if.read = 1'b1; m1_if.address = 17'h00041;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin tests_failed++; $display("FAIL rmr_rdv[%0d]: got %b want 00", c, {m0_if.readdatavalid, m1_if.readdatavalid}); end
            tests_run++; if ({m0_if.waitrequest, m1_if.waitrequest, mem_chipselect} !== 3'b110) begin tests_failed++; $display("FAIL rmr_wait_cs[%0d]: got %b want 110", c, {m0_if.waitrequest, m1_if.waitrequest, mem_chipselect}); end
            next_cycle();
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin tests_failed++; $display("FAIL rmr_first_tie: got %b want 01", {m0_if.waitrequest, m1_if.waitrequest}); end
        next_cycle();
        idle_all();
        next_cycle();
    endtask

`ifdef ONCHIP_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        m0_if.write = 1'b1; m0_if.address = 17'h00050; m0_lock = 1'b1;
        m1_if.write = 1'b1; m1_if.address = 17'h00060;
        @(negedge clk);
        tests_run++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin tests_failed++; $display("FAIL lock_first: got %b want 01", {m0_if.waitrequest, m1_if.waitrequest}); end
        next_cycle();
        m0_if.write = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++; if ({m1_if.waitrequest, mem_chipselect} !== 2'b10) begin tests_failed++; $display("FAIL lock_hold[%0d]: got %b want 10", c, {m1_if.waitrequest, mem_chipselect}); end
            next_cycle();
        end
        m0_lock = 1'b0;
        @(negedge clk);
        tests_run++; if (m1_if.waitrequest !== 1'b0) begin tests_failed++; $display("FAIL lock_release: got %b want 0", m1_if.waitrequest); end
        next_cycle();
        idle_all();
        next_cycle();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        reset_n = 1'b0;
        #1;
        test_reset();
        test_single_read();
        test_write_read();
        test_tie();
        test_contention();
        test_reset_mid_read();
`ifdef ONCHIP_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/onchip_mem_port_arbiter.md
# onchip_mem_port_arbiter

Two-requester round-robin arbiter sharing the 16-bit port (s2) of the system's dual-port on-chip frame memory between two Avalon-MM masters, e.g. video scan-out and a pixel-write DMA. The block muxes address, write data and byte enables onto the single memory port and tracks the one-cycle read latency. It returns read data with `readdatavalid` to the requester that issued the read. The block sits between the masters and the memory's `address2`/`writedata2`/`readdata2` port and drives `chipselect2`/`write2`/`clken2`.

## Interface
- `ADDR_W`, 17, word address width of the memory port.
- `DATA_W`, 16, data width of the memory port.
- `BE_W`, 2, byte-enable width (`DATA_W`/8).

- `clk`  in  1  single clock; also clocks memory port 2.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_address` / `m1_address`  in  `ADDR_W`  requester word address.
- `m0_read` / `m1_read`  in  1  read request.
- `m0_write` / `m1_write`  in  1  write request.
- `m0_writedata` / `m1_writedata`  in  `DATA_W`  write data.
- `m0_byteenable` / `m1_byteenable`  in  `BE_W`  byte enables.
- `m0_waitrequest` / `m1_waitrequest`  out  1  high = request not accepted this cycle.
- `m0_readdata` / `m1_readdata`  out  `DATA_W`  read data.
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  read data valid strobe.
- `mem_address`  out  `ADDR_W`  to `address2`.
- `mem_chipselect`  out  1  to `chipselect2`.
- `mem_write`  out  1  to `write2`.
- `mem_writedata`  out  `DATA_W`  to `writedata2`.
- `mem_byteenable`  out  `BE_W`  to `byteenable2`.
- `mem_clken`  out  1  to `clken2`; constant 1.
- `mem_readdata`  in  `DATA_W`  from `readdata2`.

## Operation
- A requester is active when `read` or `write` is high.
- If both `read` and `write` are high, the request is treated as a write (protocol error; no read is issued).
- Grant, combinational each cycle:
  - One requester active: it is granted.
  - Both active: the requester not in `last_grant` is granted.
  - None active: no grant, and `mem_chipselect` = 0.
- `last_grant` is a register updated only on cycles that have a grant.
- Granted requester:
  - Its `waitrequest` = 0.
  - Its address, data and byte enables drive the memory.
  - `mem_chipselect` = 1; `mem_write` = its write.
- Non-granted requesters see `waitrequest` = 1 and must hold their request stable.
- Read issue: registers `rd_pending` = 1 and `rd_owner` = grant id.
- Read return, next cycle: `mx_readdata` = `mem_readdata` for `rd_owner`, with `mx_readdatavalid` = 1 for exactly one cycle.
- `readdata` of the non-owner is 0.
- Writes produce no response.
- Reset values:
  - `last_grant` = 1, so m0 wins the first tie.
  - `rd_pending` = 0; all `readdatavalid` = 0.
  - While `reset_n` is low, all `waitrequest` = 1 and `mem_chipselect` = 0.
- Reset asserted with a read pending: the read is dropped and no `readdatavalid` is issued.

## Timing
- Accept latency: 0 cycles when uncontended.
- Contended worst case: 1 cycle of wait per competing access (round-robin bound).
- Read latency: `readdatavalid` is asserted exactly 1 cycle after the accept cycle (memory address registered, output unregistered).
- Throughput: one access per cycle.
- Back-to-back reads from alternating requesters give back-to-back valids with alternating owners.
- Write in cycle N followed by a read of the same address in N+1 returns the new data (same port, so no mixed-port hazard).
- Port 1 (32-bit) traffic is outside this block; this block makes no mixed-port ordering guarantee.

## Configuration
- `ONCHIP_ARB_LOCK_EN`
  - Defined: adds inputs `m0_lock` and `m1_lock`.
  - While the requester named in `last_grant` holds `lock` high, the other requester is never granted, even if the lock holder is idle.
  - Lock is honoured only after the requester has received at least one grant.
  - Lock deasserted: normal round-robin resumes the next cycle.
  - Undefined: no lock ports; pure round-robin.

## Structure
- Package `onchip_arb_pkg` holds:
  - default `ADDR_W`/`DATA_W`/`BE_W` constants;
  - `req_id_t` (1-bit requester id);
  - the `LAST_GRANT_RST` constant.
- Sub-module `rr_arb2`: two-way round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`, optional `lock`.
  - Outputs: `gnt[1:0]`, `gnt_id`.
  - Purely combinational; the `last_grant` register stays in the top.

## Test plan
- Single read: m0 reads 0x00010, memory holds 0xBEEF → `m0_waitrequest` = 0 in cycle 0; `m0_readdatavalid` = 1 with 0xBEEF in cycle 1; m1 outputs stay idle.
- Tie after reset: m0 and m1 both read in the same cycle → m0 granted first; m1 granted next cycle; valids arrive in cycles 1 and 2 with owners m0 then m1.
- Sustained contention: both masters write for 8 cycles → grants alternate m0,m1,m0,…; each master completes exactly 4 writes; memory contents match byte enables (`byteenable` = 2'b01 updates only the low byte).
- Write-then-read: m1 writes 0x1234 to 0x1FFFF, then m0 reads 0x1FFFF the next cycle → m0 receives 0x1234.
- Reset mid-read: `reset_n` goes low in the cycle after a read accept → no `readdatavalid`; all `waitrequest` = 1 during reset; m0 wins the first tie after release.
- With `ONCHIP_ARB_LOCK_EN` defined: m0 granted with `m0_lock` = 1 and m1 requesting for 5 cycles → m1 waits all 5; m0 drops `lock` → m1 granted next cycle.
